// File: rtl/alu_mc.sv
// Multicycle WIDTH-bit ALU with valid/ready on both sides; MUL is iterative shift-add.
// Define ALU_DIV_EN to build the restoring divider (opcode 1010) and drive DZ.
//
// state | meaning
// IDLE  | waiting for an operation, in_ready high
// BUSY  | MUL/DIV iterating, one step per clock
// DONE  | result and flags held until out_ready
module alu_mc #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [3:0]           ALU_Sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   Y,
  output logic                 Z,
  output logic                 N,
  output logic                 C,
  output logic                 V,
  output logic                 DZ
);

  localparam int YW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  opa_q, opa_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic [YW-1:0]     y_q, y_d;
  logic              z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
`ifdef ALU_DIV_EN
  logic [WIDTH-1:0]  opb_q, opb_d;
  logic              div_q, div_d;
  logic              dz_q, dz_d;
  logic [WIDTH:0]    div_shift;
  logic [WIDTH:0]    div_diff;
  logic              div_ge;
`endif

  logic [WIDTH:0]    add_full, sub_full, mul_sum;
  logic [YW-1:0]     sc_y;
  logic              sc_c, sc_v, sc_mc;
  logic [WIDTH-1:0]  step_hi, step_lo;

  assign add_full = {1'b0, A} + {1'b0, B};
  assign sub_full = {1'b0, A} - {1'b0, B};

  // Single-cycle results straight from the input operands
  always_comb begin
    sc_y  = '0;
    sc_c  = 1'b0;
    sc_v  = 1'b0;
    sc_mc = 1'b0;
    case (ALU_Sel)
      4'h0: begin
        sc_y[WIDTH-1:0] = add_full[WIDTH-1:0];
        sc_c = add_full[WIDTH];
        sc_v = (A[WIDTH-1] == B[WIDTH-1]) && (add_full[WIDTH-1] != A[WIDTH-1]);
      end
      4'h1: begin
        sc_y[WIDTH-1:0] = sub_full[WIDTH-1:0];
        sc_c = sub_full[WIDTH];
        sc_v = (A[WIDTH-1] != B[WIDTH-1]) && (sub_full[WIDTH-1] != A[WIDTH-1]);
      end
      4'h2: sc_y[WIDTH-1:0] = A & B;
      4'h3: sc_y[WIDTH-1:0] = A | B;
      4'h4: sc_y[WIDTH-1:0] = A ^ B;
      4'h5: sc_y[WIDTH-1:0] = {A[WIDTH-2:0], 1'b0};
      4'h6: sc_y[WIDTH-1:0] = {1'b0, A[WIDTH-1:1]};
      4'h7: sc_mc = 1'b1;
      4'h8: sc_y[0] = ($signed(A) < $signed(B));
      4'h9: sc_y[0] = (A == B);
`ifdef ALU_DIV_EN
      4'hA: sc_mc = 1'b1;
`endif
      4'hB: sc_y[WIDTH-1:0] = {A[WIDTH-1], A[WIDTH-1:1]};
      default: ;
    endcase
  end

  // One iteration: MUL adds the multiplicand into the high half and shifts right;
  // DIV shifts the dividend into the remainder and subtracts when it fits.
  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opa_q} : '0);

`ifdef ALU_DIV_EN
  assign div_shift = {hi_q, lo_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opb_q});
  assign div_diff  = div_shift - {1'b0, opb_q};
`endif

  always_comb begin
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef ALU_DIV_EN
    if (div_q) begin
      step_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], div_ge};
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    y_d     = y_q;
    z_d     = z_q;
    n_d     = n_q;
    c_d     = c_q;
    v_d     = v_q;
`ifdef ALU_DIV_EN
    opb_d   = opb_q;
    div_d   = div_q;
    dz_d    = dz_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opa_d = A;
          hi_d  = '0;
          lo_d  = B;
`ifdef ALU_DIV_EN
          opb_d = B;
          div_d = (ALU_Sel == 4'hA);
          dz_d  = 1'b0;
          if (ALU_Sel == 4'hA) lo_d = A;
`endif
          if (sc_mc) begin
            state_d = BUSY;
            cnt_d   = CW'(WIDTH);
            y_d     = '0;
            z_d     = 1'b0;
            n_d     = 1'b0;
            c_d     = 1'b0;
            v_d     = 1'b0;
          end else begin
            state_d = DONE;
            y_d     = sc_y;
            z_d     = (sc_y == '0);
            n_d     = sc_y[YW-1];
            c_d     = sc_c;
            v_d     = sc_v;
          end
        end
      end
      BUSY: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          y_d     = {step_hi, step_lo};
          z_d     = ({step_hi, step_lo} == '0);
          n_d     = step_hi[WIDTH-1];
          c_d     = 1'b0;
          v_d     = 1'b0;
`ifdef ALU_DIV_EN
          dz_d    = div_q && (opb_q == '0);
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      y_q     <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
`ifdef ALU_DIV_EN
      opb_q   <= '0;
      div_q   <= 1'b0;
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      y_q     <= y_d;
      z_q     <= z_d;
      n_q     <= n_d;
      c_q     <= c_d;
      v_q     <= v_d;
`ifdef ALU_DIV_EN
      opb_q   <= opb_d;
      div_q   <= div_d;
      dz_q    <= dz_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE) && rst_n;
  assign out_valid = (state_q == DONE);
  assign Y = y_q;
  assign Z = z_q;
  assign N = n_q;
  assign C = c_q;
  assign V = v_q;
`ifdef ALU_DIV_EN
  assign DZ = dz_q;
`else
  assign DZ = 1'b0;
`endif

endmodule
